// File: rtl/countdown_sequencer.sv
// Minute:second countdown sequencer. Values are edited in BCD, then counted
// down once per TICK_DIV clocks; on expiry the display flashes at 2 Hz.
module countdown_sequencer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       tick,
  output logic       done,
  output logic       blank
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_TERM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2 - 1);

  localparam logic [2:0] ST_RESET   = 3'd4;
  localparam logic [2:0] ST_SET_SEC = 3'd0;
  localparam logic [2:0] ST_SET_MIN = 3'd1;
  localparam logic [2:0] ST_TIMER   = 3'd2;

  typedef enum logic [1:0] {IDLE, EDIT, RUN, EXPIRED} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          inc_prev_q;
  logic          tick_q, tick_d, done_q, done_d, blank_q, blank_d;
  logic          inc_rise, pre_term, last_step;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Caller guarantees v != 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign inc_rise  = inc & ~inc_prev_q;
  assign pre_term  = (pre_q == PRE_TERM);
  assign last_step = pre_term && (sec_q == 8'h01) && (min_q == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    if (state == ST_RESET) begin
      fsm_d = IDLE;
    end else begin
      case (fsm_q)
        IDLE, EDIT: begin
          if (state == ST_TIMER)
            fsm_d = (sec_q == 8'h00 && min_q == 8'h00) ? EXPIRED : RUN;
          else if (state == ST_SET_SEC || state == ST_SET_MIN)
            fsm_d = EDIT;
        end
        RUN:     if (last_step) fsm_d = EXPIRED;
        default: ;
      endcase
    end
  end

  // Value and prescaler; the prescaler idles at zero outside RUN/EXPIRED.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    pre_d = '0;
    if (state == ST_RESET) begin
      sec_d = 8'h00;
      min_d = 8'h00;
    end else begin
      case (fsm_q)
        EDIT: begin
          if (inc_rise && state == ST_SET_SEC) sec_d = bcd_inc(sec_q);
          if (inc_rise && state == ST_SET_MIN) min_d = bcd_inc(min_q);
        end
        RUN: begin
          pre_d = pre_term ? '0 : pre_q + 1'b1;
          if (pre_term) begin
            if (sec_q != 8'h00) begin
              sec_d = bcd_dec(sec_q);
            end else begin
              sec_d = 8'h59;
              min_d = bcd_dec(min_q);
            end
          end
        end
        EXPIRED: pre_d = pre_term ? '0 : pre_q + 1'b1;
        default: ;
      endcase
    end
  end

  // done lags the FSM by one cycle so it is high only once EXPIRED is held.
  always_comb begin
    tick_d  = 1'b0;
    done_d  = 1'b0;
    blank_d = 1'b0;
    if (state != ST_RESET) begin
      case (fsm_q)
        RUN:     tick_d = pre_term;
        EXPIRED: begin
          done_d  = 1'b1;
          blank_d = (pre_term || pre_q == PRE_HALF) ? ~blank_q : blank_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      pre_q      <= '0;
      inc_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      pre_q      <= pre_d;
      inc_prev_q <= inc;
      tick_q     <= tick_d;
      done_q     <= done_d;
      blank_q    <= blank_d;
    end
  end

  assign sec_bcd = sec_q;
  assign min_bcd = min_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random stimulus,
// all checked against a seconds-count reference model.
module tb_countdown_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       inc;
  logic [7:0] sec_bcd, min_bcd;
  logic       tick, done, blank;

  countdown_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .state(state), .inc(inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .tick(tick), .done(done), .blank(blank)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: mode 0 idle, 1 edit, 2 run, 3 expired; value as total seconds.
  int m_mode, m_secs, m_pre;
  bit m_tick, m_done, m_blank, m_prev;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_pre = 0;
    m_tick = 0; m_done = 0; m_blank = 0; m_prev = 0;
  endtask

  task automatic model_step(input int st, input bit in_v);
    bit rise;
    bit was_exp;
    rise    = in_v && !m_prev;
    m_prev  = in_v;
    was_exp = (m_mode == 3);
    if (st == 4) begin
      m_mode = 0; m_secs = 0; m_pre = 0; m_tick = 0; m_done = 0; m_blank = 0;
      return;
    end
    m_tick = 0;
    m_done = was_exp;
    case (m_mode)
      0, 1: begin
        m_blank = 0;
        if (st == 2) begin
          m_pre  = 0;
          m_mode = (m_secs == 0) ? 3 : 2;
        end else begin
          if (m_mode == 1 && rise && st == 0)
            m_secs = (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60;
          if (m_mode == 1 && rise && st == 1)
            m_secs = ((m_secs / 60 + 1) % 60) * 60 + m_secs % 60;
          if (st == 0 || st == 1) m_mode = 1;
        end
      end
      2: begin
        m_blank = 0;
        if (m_pre == TD - 1) begin
          m_tick = 1;
          m_secs = m_secs - 1;
          if (m_secs == 0) m_mode = 3;
        end
        m_pre = (m_pre + 1) % TD;
      end
      default: begin
        if (m_pre == TD / 2 - 1 || m_pre == TD - 1) m_blank = !m_blank;
        m_pre = (m_pre + 1) % TD;
      end
    endcase
  endtask

  task automatic check_all();
    chk_eq("sec_bcd", sec_bcd, to_bcd(m_secs % 60));
    chk_eq("min_bcd", min_bcd, to_bcd(m_secs / 60));
    chk_eq("tick", tick, m_tick);
    chk_eq("done", done, m_done);
    chk_eq("blank", blank, m_blank);
  endtask

  task automatic cyc(input logic [2:0] st, input logic in_v);
    state = st;
    inc   = in_v;
    @(posedge clk);
    model_step(st, in_v);
    #1 check_all();
  endtask

  task automatic arst();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
  endtask

  task automatic load(input int mins, input int secs);
    cyc(3'd4, 1'b0);
    cyc(3'd0, 1'b0);
    repeat (secs) begin cyc(3'd0, 1'b1); cyc(3'd0, 1'b0); end
    cyc(3'd1, 1'b0);
    repeat (mins) begin cyc(3'd1, 1'b1); cyc(3'd1, 1'b0); end
  endtask

  initial begin
    int ticks[$];
    int done_at, toggles, nticks;
    logic prev_blank;
    logic [7:0] sec_after_first;

    rst = 1'b1; state = 3'd4; inc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b0;

    // 61 increments wrap seconds through 59 without touching minutes.
    cyc(3'd4, 1'b0);
    cyc(3'd0, 1'b0);
    repeat (61) begin cyc(3'd0, 1'b1); cyc(3'd0, 1'b0); end
    chk_eq("wrap61_sec", sec_bcd, 8'h01);
    chk_eq("wrap61_min", min_bcd, 8'h00);

    // Holding inc high counts once.
    cyc(3'd0, 1'b1); cyc(3'd0, 1'b1); cyc(3'd0, 1'b1); cyc(3'd0, 1'b0);
    chk_eq("hold_inc_sec", sec_bcd, 8'h02);

    // 01:00 countdown: tick timing and expiry latency.
    load(1, 0);
    cyc(3'd2, 1'b0);
    done_at = -1;
    sec_after_first = 8'hxx;
    for (int k = 1; k <= 250; k++) begin
      cyc(3'd5, 1'b0);
      if (tick === 1'b1) begin
        ticks.push_back(k);
        if (ticks.size() == 1) sec_after_first = sec_bcd;
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    chk_eq("first_tick_cycle", ticks.size() > 0 ? ticks[0] : -1, 4);
    chk_eq("second_tick_cycle", ticks.size() > 1 ? ticks[1] : -1, 8);
    chk_eq("tick_count", ticks.size(), 60);
    chk_eq("sec_after_first_tick", sec_after_first, 8'h59);
    chk_eq("done_cycle", done_at, 241);

    // 00:00 goes straight to EXPIRED; blank flashes every 2 cycles.
    load(0, 0);
    cyc(3'd2, 1'b0);
    cyc(3'd3, 1'b0);
    chk_eq("zero_done", done, 1'b1);
    toggles = 0; nticks = 0; prev_blank = blank;
    repeat (12) begin
      cyc(3'($urandom_range(5, 7)), 1'($urandom_range(0, 1)));
      if (blank !== prev_blank) toggles++;
      if (tick === 1'b1) nticks++;
      prev_blank = blank;
    end
    chk_eq("zero_blank_toggles", toggles, 6);
    chk_eq("zero_no_tick", nticks, 0);

    // Edits are ignored while running.
    load(0, 10);
    cyc(3'd2, 1'b0);
    repeat (10) begin cyc(3'd1, 1'b1); cyc(3'd1, 1'b0); end
    chk_eq("run_min_frozen", min_bcd, 8'h00);
    chk_eq("run_sec_continues", sec_bcd, 8'h05);

    // Async reset mid-RUN leaves no residual tick.
    load(0, 5);
    cyc(3'd2, 1'b0);
    repeat (6) cyc(3'd5, 1'b0);
    @(negedge clk);
    arst();
    nticks = 0;
    repeat (20) begin cyc(3'd3, 1'b0); if (tick === 1'b1) nticks++; end
    chk_eq("rst_no_tick", nticks, 0);
    chk_eq("rst_done", done, 1'b0);

    // RESET code clears EXPIRED and editing resumes.
    load(0, 1);
    cyc(3'd2, 1'b0);
    repeat (8) cyc(3'd6, 1'b0);
    chk_eq("exp_done", done, 1'b1);
    cyc(3'd4, 1'b0);
    chk_eq("clr_done", done, 1'b0);
    chk_eq("clr_blank", blank, 1'b0);
    cyc(3'd0, 1'b0);
    cyc(3'd0, 1'b1);
    chk_eq("edit_after_clr", sec_bcd, 8'h01);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] st;
      st = 3'($urandom_range(0, 7));
      if (st == 3'd4 && ($urandom % 8) != 0) st = 3'd5;
      if (($urandom % 600) == 0) arst();
      cyc(st, 1'(($urandom % 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
